// File: rtl/vga_fb_arbiter_if.sv
// Bundle of the frame-buffer arbiter's client-side and RAM-side signals.
// slave is the arbiter's view; master is the view of the surrounding system.
interface vga_fb_arbiter_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 15
);
    logic              frame_start;
    logic              disp_req;
    logic [ADDR_W-1:0] disp_addr;
    logic              disp_valid;
    logic [DATA_W-1:0] disp_data;
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              clear_start;
    logic              clear_busy;
    logic              clear_done;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    modport slave (
        input  frame_start, disp_req, disp_addr, wr_valid, wr_addr, wr_data,
               clear_start, ram_rdata,
        output disp_valid, disp_data, wr_ready, clear_busy, clear_done,
               ram_addr, ram_we, ram_wdata
    );

    modport master (
        output frame_start, disp_req, disp_addr, wr_valid, wr_addr, wr_data,
               clear_start, ram_rdata,
        input  disp_valid, disp_data, wr_ready, clear_busy, clear_done,
               ram_addr, ram_we, ram_wdata
    );
endinterface

// File: rtl/vga_fb_arbiter.sv
// Single-port frame-buffer arbiter: scan-out reads always win, then the
// frame-synchronised clear sweep, then plotter writes.
module vga_fb_arbiter #(
    parameter int                 DATA_W      = 8,
    parameter int                 DEPTH       = 19200,
    parameter logic [DATA_W-1:0]  CLEAR_VALUE = 8'h00
) (
    input  logic            clock,
    input  logic            reset,
    vga_fb_arbiter_if.slave bus
);
    localparam int                ADDR_W    = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        C_IDLE = 2'd0,
        C_PEND = 2'd1,
        C_RUN  = 2'd2
    } clr_state_t;

    clr_state_t        state_r, state_s;
    logic [ADDR_W-1:0] clr_addr_r, clr_addr_s;
    logic              done_r, done_s;
    logic [ADDR_W-1:0] ram_addr_r, ram_addr_s;
    logic              ram_we_r, ram_we_s;
    logic [DATA_W-1:0] ram_wdata_r, ram_wdata_s;
    logic              rd_pend_r;
    logic              disp_valid_r;
    logic              wr_ready_s;

    assign wr_ready_s     = !bus.disp_req && (state_r != C_RUN);
    assign bus.wr_ready   = wr_ready_s;
    assign bus.disp_valid = disp_valid_r;
    assign bus.disp_data  = bus.ram_rdata;
    assign bus.clear_busy = (state_r != C_IDLE);
    assign bus.clear_done = done_r;
    assign bus.ram_addr   = ram_addr_r;
    assign bus.ram_we     = ram_we_r;
    assign bus.ram_wdata  = ram_wdata_r;

    // Clear FSM next state and the single RAM grant for this cycle.
    always_comb begin
        state_s     = state_r;
        clr_addr_s  = clr_addr_r;
        done_s      = 1'b0;
        ram_addr_s  = ram_addr_r;
        ram_we_s    = 1'b0;
        ram_wdata_s = ram_wdata_r;
        case (state_r)
            C_IDLE: begin
                if (bus.clear_start) begin
                    state_s = C_PEND;
                end else begin
                    state_s = C_IDLE;
                end
            end
            C_PEND: begin
                if (bus.frame_start) begin
                    state_s    = C_RUN;
                    clr_addr_s = {ADDR_W{1'b0}};
                end else begin
                    state_s = C_PEND;
                end
            end
            C_RUN: begin
                if (!bus.disp_req) begin
                    ram_we_s    = 1'b1;
                    ram_addr_s  = clr_addr_r;
                    ram_wdata_s = CLEAR_VALUE;
                    if (clr_addr_r == LAST_ADDR) begin
                        state_s    = C_IDLE;
                        clr_addr_s = {ADDR_W{1'b0}};
                        done_s     = 1'b1;
                    end else begin
                        clr_addr_s = clr_addr_r + ADDR_W'(1);
                    end
                end else begin
                    state_s = C_RUN;
                end
            end
            default: begin
                state_s    = C_IDLE;
                clr_addr_s = {ADDR_W{1'b0}};
            end
        endcase
        // Plotter is only reachable when wr_ready is high, so it never collides with the sweep.
        if (bus.disp_req) begin
            ram_addr_s = bus.disp_addr;
            ram_we_s   = 1'b0;
        end else if (wr_ready_s && bus.wr_valid && (bus.wr_addr <= LAST_ADDR)) begin
            ram_we_s    = 1'b1;
            ram_addr_s  = bus.wr_addr;
            ram_wdata_s = bus.wr_data;
        end else begin
            ram_we_s = ram_we_s;
        end
    end

    // State, RAM port and read-return pipeline registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r      <= C_IDLE;
            clr_addr_r   <= {ADDR_W{1'b0}};
            done_r       <= 1'b0;
            ram_addr_r   <= {ADDR_W{1'b0}};
            ram_we_r     <= 1'b0;
            ram_wdata_r  <= {DATA_W{1'b0}};
            rd_pend_r    <= 1'b0;
            disp_valid_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            clr_addr_r   <= clr_addr_s;
            done_r       <= done_s;
            ram_addr_r   <= ram_addr_s;
            ram_we_r     <= ram_we_s;
            ram_wdata_r  <= ram_wdata_s;
            rd_pend_r    <= bus.disp_req;
            disp_valid_r <= rd_pend_r;
        end
    end
endmodule
